// File: rtl/stack_alu_pkg.sv
// Shared constants for the stack ALU RPN sequencer: ALU opcodes, token op codes, FSM states.
package stack_alu_pkg;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_PUSH = 3'b110;
  localparam logic [2:0] ALU_POP  = 3'b111;

  localparam logic [1:0] TOK_ADD = 2'b00;
  localparam logic [1:0] TOK_MUL = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH,
    S_EXEC,
    S_POP1,
    S_POP2,
    S_PUSHR,
    S_FPOP,
    S_FCAP,
    S_DRAIN,
    S_RESULT
  } state_t;

endpackage

// File: rtl/stack_alu_rpn_ctrl.sv
// Expands RPN tokens into STACK_BASED_ALU opcode sequences; operand 2 cycles, operator 5 cycles.
// Tokens are taken only in IDLE; a pending result stalls the token stream until res_ready.
module stack_alu_rpn_ctrl
  import stack_alu_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_is_op,
  input  logic [1:0]   tok_op,
  input  logic [N-1:0] tok_data,
  input  logic         tok_last,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_overflow,
  output logic         res_error,
  output logic         alu_rst,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_input_data,
  input  logic [N-1:0] alu_output_data,
  input  logic         alu_overflow,
  input  logic         alu_success
);

  localparam int DW = $clog2(MAX_SIZE + 1);
  localparam logic [DW-1:0] DMAX = DW'(MAX_SIZE);
  localparam logic [DW-1:0] D0   = DW'(0);
  localparam logic [DW-1:0] D1   = DW'(1);
  localparam logic [DW-1:0] D2   = DW'(2);

  state_t        state, state_nx;
  logic [DW-1:0] depth, depth_nx;
  logic [DW-1:0] depth_inc;
  logic [N-1:0]  acc, acc_nx;
  logic          is_mul, is_mul_nx;
  logic          last, last_nx;
  logic          ovf, ovf_nx;
  logic          err, err_nx;
  logic          tok_fire;

  assign alu_rst      = ~rst;
  assign tok_ready    = (state == S_IDLE) & rst;
  assign tok_fire     = tok_valid & tok_ready;
  assign depth_inc    = depth + 1'b1;
  assign res_valid    = (state == S_RESULT);
  assign res_data     = (res_valid && !err) ? acc : '0;
  assign res_overflow = res_valid & ovf;
  assign res_error    = res_valid & err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      depth  <= '0;
      acc    <= '0;
      is_mul <= 1'b0;
      last   <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      depth  <= depth_nx;
      acc    <= acc_nx;
      is_mul <= is_mul_nx;
      last   <= last_nx;
      ovf    <= ovf_nx;
      err    <= err_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    depth_nx       = depth;
    acc_nx         = acc;
    is_mul_nx      = is_mul;
    last_nx        = last;
    ovf_nx         = ovf;
    err_nx         = err;
    alu_opcode     = ALU_IDLE;
    alu_input_data = '0;
    case (state)
      S_IDLE: begin
        if (tok_fire) begin
          last_nx = tok_last;
          if (!tok_is_op) begin
            if (depth == DMAX) begin
              err_nx   = 1'b1;
              state_nx = S_DRAIN;
            end else begin
              acc_nx   = tok_data;
              state_nx = S_PUSH;
            end
          end else if (depth < D2 || (tok_op != TOK_ADD && tok_op != TOK_MUL)) begin
            err_nx   = 1'b1;
            state_nx = S_DRAIN;
          end else begin
            is_mul_nx = (tok_op == TOK_MUL);
            state_nx  = S_EXEC;
          end
        end
      end
      // Both pushes share the end-of-expression check on the post-push depth.
      S_PUSH, S_PUSHR: begin
        alu_opcode     = ALU_PUSH;
        alu_input_data = acc;
        depth_nx       = depth_inc;
        if (!last) begin
          state_nx = S_IDLE;
        end else if (depth_inc == D1) begin
          state_nx = S_FPOP;
        end else begin
          err_nx   = 1'b1;
          state_nx = S_DRAIN;
        end
      end
      S_EXEC: begin
        alu_opcode = is_mul ? ALU_MUL : ALU_ADD;
        state_nx   = S_POP1;
      end
      // The ALU answer from EXEC lands here while the first operand pop is issued.
      S_POP1: begin
        alu_opcode = ALU_POP;
        depth_nx   = depth - 1'b1;
        acc_nx     = alu_output_data;
        ovf_nx     = ovf | alu_overflow;
        if (!alu_success) begin
          err_nx   = 1'b1;
          state_nx = S_DRAIN;
        end else begin
          state_nx = S_POP2;
        end
      end
      S_POP2: begin
        alu_opcode = ALU_POP;
        depth_nx   = depth - 1'b1;
        state_nx   = S_PUSHR;
      end
      S_FPOP: begin
        alu_opcode = ALU_POP;
        depth_nx   = depth - 1'b1;
        state_nx   = S_FCAP;
      end
      S_FCAP: begin
        acc_nx = alu_output_data;
        if (!alu_success) begin
          err_nx   = 1'b1;
          state_nx = S_DRAIN;
        end else begin
          state_nx = S_RESULT;
        end
      end
      S_DRAIN: begin
        if (depth != D0) begin
          alu_opcode = ALU_POP;
          depth_nx   = depth - 1'b1;
        end
        if (depth <= D1) state_nx = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          acc_nx   = '0;
          ovf_nx   = 1'b0;
          err_nx   = 1'b0;
          last_nx  = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_alu_rpn_ctrl.sv
// Bench for stack_alu_rpn_ctrl: behavioural stack ALU beside the DUT, queue-based RPN reference model.
module tb_stack_alu_rpn_ctrl;

  localparam int N    = 4;
  localparam int MAXS = 8;

  typedef struct packed {
    logic         is_op;
    logic [1:0]   op;
    logic [N-1:0] data;
    logic         last;
  } tok_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic         tok_is_op = 1'b0;
  logic [1:0]   tok_op = 2'b00;
  logic [N-1:0] tok_data = '0;
  logic         tok_last = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] res_data;
  logic         res_overflow;
  logic         res_error;
  logic         alu_rst;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_input_data;
  logic [N-1:0] alu_output_data;
  logic         alu_overflow;
  logic         alu_success;

  always #5 clk = ~clk;

  stack_alu_rpn_ctrl #(.N(N), .MAX_SIZE(MAXS)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_op(tok_op), .tok_data(tok_data), .tok_last(tok_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_overflow(res_overflow), .res_error(res_error),
    .alu_rst(alu_rst), .alu_opcode(alu_opcode), .alu_input_data(alu_input_data),
    .alu_output_data(alu_output_data), .alu_overflow(alu_overflow), .alu_success(alu_success)
  );

  int           nassert = 0;
  int           nfail   = 0;
  tok_t         tq[$];
  logic [2:0]   opq[$];
  logic [2:0]   exp_ops[$];
  logic [N-1:0] exp_res;
  logic         exp_ovf;
  logic         exp_err;

  function automatic int sext(input logic [N-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [N-1:0] wrapn(input int v);
    return v[N-1:0];
  endfunction

  function automatic logic ovfn(input int v);
    return (v > (2 ** (N - 1)) - 1) || (v < -(2 ** (N - 1)));
  endfunction

  function automatic int alu_calc(input logic [2:0] opc, input int a, input int b);
    return (opc == 3'b101) ? a * b : a + b;
  endfunction

  // Behavioural STACK_BASED_ALU: non-destructive add/mul, results one cycle after issue.
  logic [N-1:0] astk [MAXS];
  int           asz;
  always @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      asz             <= 0;
      alu_output_data <= '0;
      alu_overflow    <= 1'b0;
      alu_success     <= 1'b0;
    end else begin
      alu_overflow <= 1'b0;
      alu_success  <= 1'b1;
      case (alu_opcode)
        3'b110: if (asz < MAXS) begin
          astk[asz] <= alu_input_data;
          asz       <= asz + 1;
        end else alu_success <= 1'b0;
        3'b111: if (asz > 0) begin
          alu_output_data <= astk[asz-1];
          asz             <= asz - 1;
        end else alu_success <= 1'b0;
        3'b100, 3'b101: if (asz >= 2) begin
          alu_output_data <= wrapn(alu_calc(alu_opcode, sext(astk[asz-1]), sext(astk[asz-2])));
          alu_overflow    <= ovfn(alu_calc(alu_opcode, sext(astk[asz-1]), sext(astk[asz-2])));
        end else alu_success <= 1'b0;
        default: ;
      endcase
    end
  end

  always @(posedge clk) if (rst && alu_opcode != 3'b000) opq.push_back(alu_opcode);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tok_t num(input int v);
    tok_t t;
    t.is_op = 1'b0; t.op = 2'b00; t.data = wrapn(v); t.last = 1'b0;
    return t;
  endfunction

  function automatic tok_t opr(input logic [1:0] o);
    tok_t t;
    t.is_op = 1'b1; t.op = o; t.data = '0; t.last = 1'b0;
    return t;
  endfunction

  // Evaluates tq with an integer stack and lists the ALU operations the expression implies.
  task automatic model();
    int stk[$];
    int a, b, r;
    bit bad;
    bad = 1'b0;
    exp_ops.delete();
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    exp_res = '0;
    for (int i = 0; i < tq.size(); i++) begin
      if (!bad) begin
        if (!tq[i].is_op) begin
          if (stk.size() == MAXS) bad = 1'b1;
          else begin
            stk.push_back(sext(tq[i].data));
            exp_ops.push_back(3'b110);
          end
        end else if (stk.size() < 2 || tq[i].op > 2'd1) begin
          bad = 1'b1;
        end else begin
          a = stk.pop_back();
          b = stk.pop_back();
          r = (tq[i].op == 2'd1) ? a * b : a + b;
          if (ovfn(r)) exp_ovf = 1'b1;
          exp_ops.push_back((tq[i].op == 2'd1) ? 3'b101 : 3'b100);
          exp_ops.push_back(3'b111);
          exp_ops.push_back(3'b111);
          exp_ops.push_back(3'b110);
          stk.push_back(sext(wrapn(r)));
        end
      end
    end
    if (!bad && stk.size() == 1) begin
      exp_ops.push_back(3'b111);
      exp_res = wrapn(stk[0]);
    end else begin
      exp_err = 1'b1;
      for (int j = 0; j < stk.size(); j++) exp_ops.push_back(3'b111);
    end
  endtask

  task automatic send_tok(input tok_t t, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = t.is_op; tok_op = t.op; tok_data = t.data; tok_last = t.last;
    while (!tok_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tok_timeout"}, 32'(n >= 200), 32'd0);
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    tok_last  = 1'b0;
  endtask

  task automatic run_expr(input string tag, input int hold);
    int n;
    logic [N-1:0] d0;
    logic o0, e0;
    n = 0;
    tq[tq.size()-1].last = 1'b1;
    opq.delete();
    model();
    for (int i = 0; i < tq.size(); i++) send_tok(tq[i], tag);
    while (!res_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_res_timeout"}, 32'(n >= 500), 32'd0);
    d0 = res_data; o0 = res_overflow; e0 = res_error;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_hold_data"}, 32'({res_data, res_overflow, res_error}), 32'({d0, o0, e0}));
      check({tag, "_hold_tok_ready"}, 32'(tok_ready), 32'd0);
    end
    check({tag, "_data"}, 32'(res_data), 32'(exp_res));
    check({tag, "_ovf"}, 32'(res_overflow), 32'(exp_ovf));
    check({tag, "_err"}, 32'(res_error), 32'(exp_err));
    check({tag, "_nops"}, 32'(opq.size()), 32'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < opq.size(); i++)
      check({tag, "_opcode"}, 32'(opq[i]), 32'(exp_ops[i]));
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_valid_cleared"}, 32'(res_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(tok_ready), 32'd1);
    check({tag, "_alu_depth"}, 32'(asz), 32'd0);
    tq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tok_ready"}, 32'(tok_ready), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_res_flags"}, 32'({res_overflow, res_error}), 32'd0);
    check({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
    check({tag, "_alu_input"}, 32'(alu_input_data), 32'd0);
    check({tag, "_alu_rst"}, 32'(alu_rst), 32'd1);
  endtask

  task automatic gen_random();
    int nops, nnum, d, fault;
    nops  = $urandom_range(0, 5);
    nnum  = nops + 1;
    fault = $urandom_range(0, 5);
    if (fault == 0 && nops > 0) nops--;
    d = 0;
    while (nnum > 0 || nops > 0) begin
      if (d >= 2 && nops > 0 && (nnum == 0 || $urandom_range(0, 1) == 1)) begin
        tq.push_back(opr(2'($urandom_range(0, 1))));
        nops--;
        d--;
      end else begin
        tq.push_back(num(int'($urandom_range(0, 15))));
        nnum--;
        d++;
      end
    end
    if (fault == 1 && tq[tq.size()-1].is_op) tq[tq.size()-1].op = 2'($urandom_range(2, 3));
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_release_ready", 32'(tok_ready), 32'd1);
    check("reset_release_alu_rst", 32'(alu_rst), 32'd0);

    tq = '{num(3), num(2), opr(2'b00)};
    run_expr("add_3_2", 0);
    tq = '{num(3), num(4), opr(2'b01)};
    run_expr("mul_3_4_hold", 3);
    tq = '{num(5), opr(2'b00)};
    run_expr("underflow", 1);
    tq = '{num(1), num(2)};
    run_expr("leftover", 0);
    tq = '{num(6), num(1), opr(2'b00)};
    run_expr("after_error", 0);
    for (int i = 0; i < MAXS + 1; i++) tq.push_back(num(i));
    run_expr("stack_full", 0);
    tq = '{num(7), num(-8), opr(2'b11)};
    run_expr("illegal_op", 0);

    // Abort mid-operator, then confirm a fresh expression evaluates cleanly.
    tq = '{num(3), num(2), opr(2'b00)};
    tq[2].last = 1'b1;
    for (int i = 0; i < tq.size(); i++) send_tok(tq[i], "abort");
    repeat (2) @(posedge clk);
    #1;
    check("abort_in_pop2", 32'(alu_opcode), 32'b111);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    check("abort_alu_cleared", 32'(asz), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(tok_ready), 32'd1);
    tq.delete();
    tq = '{num(2), num(3), opr(2'b00)};
    run_expr("post_abort", 0);

    for (int k = 0; k < 40; k++) begin
      gen_random();
      run_expr("rand", int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
